// File: rtl/seq_detector_param.sv
// seq_detector_param: serial sequence detector with a runtime-loadable pattern.
//
// Compares the last PAT_W accepted bits of a serial stream against a pattern
// register.  Overlapping or non-overlapping matching is selected per bit, and
// matches are counted in a saturating counter.
//
// Optional feature: define SEQDET_MASK_EN to add the pat_mask input.  A mask
// bit of 1 makes the corresponding pattern bit a don't-care.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        synchronous active-high reset
//   I            serial data bit
//   in_valid     I is accepted only when high
//   pat_load     load pat_in (and pat_mask) as the new pattern, clears history
//   pat_in       new pattern, MSB is the first bit received
//   pat_mask     (SEQDET_MASK_EN only) don't-care mask loaded with pat_in
//   overlap_en   1 = overlapping matches, 0 = restart after each match
//   cnt_clr      clear match_count (wins over a same-cycle match)
//   F            one-cycle registered match pulse
//   match_count  saturating match count
//   armed        at least PAT_W bits have been accepted since the last restart
module seq_detector_param #(
    parameter int unsigned      PAT_W       = 5,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 5'b11001,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             F,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {StEmpty, StFill, StArmed} state_e;

    state_e           state_q, state_d;
    // The oldest history bit is shifted out before it is ever compared, so
    // only the newest PAT_W-1 bits are stored.
    logic [PAT_W-2:0] history_q, history_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             f_q, f_d;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] care;
    logic             hit;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
    assign care = ~mask_q;
`else
    assign care = '1;
`endif

    assign window = {history_q, I};
    // A pattern load discards the same-cycle bit, so it can never complete a match.
    assign hit = in_valid && !pat_load && (fill_q >= FILL_LAST)
                 && (((window ^ pattern_q) & care) == '0);

    always_comb begin
        state_d   = state_q;
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        f_d       = hit;
`ifdef SEQDET_MASK_EN
        mask_d    = mask_q;
`endif

        if (pat_load) begin
            pattern_d = pat_in;
`ifdef SEQDET_MASK_EN
            mask_d    = pat_mask;
`endif
            history_d = '0;
            fill_d    = '0;
            state_d   = StEmpty;
        end else if (in_valid) begin
            if (hit && !overlap_en) begin
                history_d = '0;
                fill_d    = '0;
                state_d   = StEmpty;
            end else begin
                history_d = window[PAT_W-2:0];
                unique case (state_q)
                    StEmpty: begin
                        fill_d  = fill_q + 1'b1;
                        state_d = StFill;
                    end
                    StFill: begin
                        fill_d  = fill_q + 1'b1;
                        state_d = (fill_q == FILL_LAST) ? StArmed : StFill;
                    end
                    StArmed: begin
                        fill_d  = fill_q;
                        state_d = StArmed;
                    end
                    default: begin
                        fill_d  = '0;
                        state_d = StEmpty;
                    end
                endcase
            end
        end

        if (cnt_clr) begin
            count_d = '0;
        end else if (hit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StEmpty;
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= DEFAULT_PAT;
            count_q   <= '0;
            f_q       <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            f_q       <= f_d;
`ifdef SEQDET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign F           = f_q;
    assign match_count = count_q;
    assign armed       = (state_q == StArmed);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a default instance (CNT_W=8) and a CNT_W=2
// instance share the same stimulus; the small counter must equal min(count,3).
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       I = 1'b0;
    logic       in_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [4:0] pat_in = 5'b0;
    logic [4:0] pat_mask = 5'b0;
    logic       overlap_en = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       f1, f2, arm1, arm2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    always #5 clock = ~clock;

    seq_detector_param dut (
        .clock(clock), .reset(reset), .I(I), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap_en(overlap_en), .cnt_clr(cnt_clr), .F(f1), .match_count(cnt1), .armed(arm1)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .I(I), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in),
`ifdef SEQDET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .overlap_en(overlap_en), .cnt_clr(cnt_clr), .F(f2), .match_count(cnt2), .armed(arm2)
    );

    typedef struct {
        logic       iv;
        logic       i;
        logic       ld;
        logic [4:0] pin;
        logic       ov;
        logic       clr;
        logic       ef;
        int         ecnt;
        logic       earm;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic iv, input logic i, input logic ld,
                                input logic [4:0] pin, input logic ov, input logic clr,
                                input logic ef, input int ecnt, input logic earm);
        vec_t v;
        v.iv = iv; v.i = i; v.ld = ld; v.pin = pin; v.ov = ov; v.clr = clr;
        v.ef = ef; v.ecnt = ecnt; v.earm = earm;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, stepno, act, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, then compare just after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clock);
        in_valid = v.iv; I = v.i; pat_load = v.ld; pat_in = v.pin;
        overlap_en = v.ov; cnt_clr = v.clr;
        sb.push_back(v);
        @(posedge clock);
        #1;
        stepno++;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("F", int'(f1), int'(e.ef));
            chk("F_cnt2", int'(f2), int'(e.ef));
            chk("match_count", int'(cnt1), e.ecnt);
            chk("match_count_sat", int'(cnt2), (e.ecnt > 3) ? 3 : e.ecnt);
            chk("armed", int'(arm1), int'(e.earm));
            chk("armed_cnt2", int'(arm2), int'(e.earm));
        end
    endtask

    // Reset cycle with a live bit on the input that must be dropped.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; I = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clock);
        #1;
        stepno++;
        chk("reset_F", int'(f1), 0);
        chk("reset_count", int'(cnt1), 0);
        chk("reset_count_sat", int'(cnt2), 0);
        chk("reset_armed", int'(arm1), 0);
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Overlapping 1,1,0,0,1,(idle),1,0,0,1 then clear.
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 5'd0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 5'd0, 1, 1, 0, 0, 1));
        // Reload same pattern to flush history, then non-overlapping 9 bits.
        tbl.push_back(mk(0, 0, 1, 5'b11001, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 0, 0, 0, 1, 0));
        // in_valid gaps with I=1 while invalid.
        tbl.push_back(mk(0, 0, 1, 5'b11001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 1, 2, 1));
        // Load 10101 with a live bit (dropped), then new pattern, then old pattern.
        tbl.push_back(mk(1, 1, 1, 5'b10101, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 1, 3, 1));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(1, 0, 0, 5'd0, 1, 0, 0, 3, 1));
        tbl.push_back(mk(1, 1, 0, 5'd0, 1, 0, 0, 3, 1));
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k]);
        end

        // Saturation: clear + reload 11001, then five non-overlapping matches.
        step(mk(0, 0, 1, 5'b11001, 0, 1, 0, 0, 0));
        for (int g = 1; g <= 5; g++) begin
            step(mk(1, 1, 0, 5'd0, 0, 0, 0, g - 1, 0));
            step(mk(1, 1, 0, 5'd0, 0, 0, 0, g - 1, 0));
            step(mk(1, 0, 0, 5'd0, 0, 0, 0, g - 1, 0));
            step(mk(1, 0, 0, 5'd0, 0, 0, 0, g - 1, 0));
            step(mk(1, 1, 0, 5'd0, 0, 0, 1, g, 0));
        end
        // cnt_clr on the completing bit: count 0 while F pulses.
        step(mk(1, 1, 0, 5'd0, 0, 0, 0, 5, 0));
        step(mk(1, 1, 0, 5'd0, 0, 0, 0, 5, 0));
        step(mk(1, 0, 0, 5'd0, 0, 0, 0, 5, 0));
        step(mk(1, 0, 0, 5'd0, 0, 0, 0, 5, 0));
        step(mk(1, 1, 0, 5'd0, 0, 1, 1, 0, 0));
        for (int k = 0; k < 5; k++) begin
            step(mk(1, (k == 2 || k == 3) ? 1'b0 : 1'b1, 0, 5'd0, 0, 0,
                    (k == 4) ? 1'b1 : 1'b0, (k == 4) ? 1 : 0, 0));
        end

        // Reset mid-stream under a non-default pattern; default must return.
        step(mk(0, 0, 1, 5'b10101, 1, 0, 0, 1, 0));
        step(mk(1, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        step(mk(1, 1, 0, 5'd0, 1, 0, 0, 1, 0));
        step(mk(1, 0, 0, 5'd0, 1, 0, 0, 1, 0));
        do_reset();
        step(mk(1, 0, 0, 5'd0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
        step(mk(1, 1, 0, 5'd0, 1, 0, 0, 0, 0));
        step(mk(1, 0, 0, 5'd0, 1, 0, 0, 0, 1));
        step(mk(1, 0, 0, 5'd0, 1, 0, 0, 0, 1));
        step(mk(1, 1, 0, 5'd0, 1, 0, 1, 1, 1));

`ifdef SEQDET_MASK_EN
        // Middle two pattern bits masked: 11111 matches 11001.
        pat_mask = 5'b00110;
        step(mk(0, 0, 1, 5'b11001, 0, 0, 0, 1, 0));
        pat_mask = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            step(mk(1, 1, 0, 5'd0, 0, 0, (k == 4) ? 1'b1 : 1'b0, (k == 4) ? 2 : 1, 0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
